xd_pulse_sched: RTL

- Source-domain scheduler that shares one xd cross-domain pulse synchroniser between CH requesters.
- Accepts one-cycle request pulses from each requester and queues them per channel in saturating counters.
- Issues them one at a time, in round-robin order, as single-cycle pulses spaced at least GAP cycles apart, so that no pulse is lost when crossing into a slower clock domain.
- A registered channel ID is driven alongside each pulse and held stable for the whole gap window, so the destination domain can sample it as a quasi-static bus when the synchronised pulse arrives.

---
 rtl/xd_sched_pkg.sv | 15 +
 rtl/rr_arb.sv | 45 ++++
 rtl/xd_pulse_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/xd_sched_pkg.sv
// Shared types and helpers for the cross-domain pulse scheduler.
package xd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_t;

  // Width of an index over n items, never below one bit so CH=1 still has a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin pick over active channels, searching from a registered pointer
// that moves just past each granted channel.
module rr_arb
  import xd_sched_pkg::*;
#(
  parameter int CH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH-1:0]                active,
  input  logic                         advance,
  output logic [clog2_min1(CH)-1:0]    grant_id,
  output logic                         grant_vld
);

  localparam int IDW = clog2_min1(CH);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    // Walk from the farthest offset back to the pointer so the nearest active channel wins.
    for (int i = CH - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % CH);
      if (active[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IDW'((int'(grant_id) + 1) % CH);
    end
  end

endmodule

// File: rtl/xd_pulse_sched.sv
// Queues per-channel request pulses and issues them one at a time, round-robin,
// at least GAP cycles apart, with a channel ID held stable across each gap.
module xd_pulse_sched
  import xd_sched_pkg::*;
#(
  parameter int CH   = 4,
  parameter int GAP  = 6,
  parameter int CNTW = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH-1:0]              req,
  input  logic                       clr_ovf,
  output logic                       pulse_o,
  output logic [clog2_min1(CH)-1:0]  chan_o,
  output logic                       busy,
  output logic [CH-1:0]              ovf
);

  localparam int IDW = clog2_min1(CH);
  localparam int TW  = clog2_min1(GAP);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t          state, next_state;
  logic [CNTW-1:0] cnt [CH];
  logic [CH-1:0]   active;
  logic            any_pend;
  logic [TW-1:0]   timer;
  logic            issue_fire;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;

  always_comb begin
    active = '0;
    for (int k = 0; k < CH; k++) active[k] = |cnt[k];
  end

  assign any_pend = |active;
  assign busy     = (state != ST_IDLE) | any_pend;

  rr_arb #(.CH(CH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .advance  (issue_fire),
    .grant_id (grant_id),
    .grant_vld(grant_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (any_pend) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_GAP;
      ST_GAP:   if (timer == '0) next_state = any_pend ? ST_ISSUE : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The grant is taken on the edge into ISSUE so pulse_o and chan_o can both be flops.
  always_comb begin
    issue_fire = (next_state == ST_ISSUE) && grant_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (issue_fire) begin
      timer <= TW'(GAP - 1);
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_o <= 1'b0;
      chan_o  <= '0;
    end else begin
      pulse_o <= issue_fire;
      if (issue_fire) chan_o <= grant_id;
    end
  end

  // NOTE: the counter array is reset like any other flop, since pending events must be discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) cnt[k] <= '0;
      ovf <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (req[k] && !(issue_fire && grant_id == IDW'(k))) begin
          if (cnt[k] == CNT_MAX) ovf[k] <= 1'b1;
          else begin
            cnt[k] <= cnt[k] + CNTW'(1);
            if (clr_ovf) ovf[k] <= 1'b0;
          end
        end else begin
          if (!req[k] && issue_fire && grant_id == IDW'(k)) cnt[k] <= cnt[k] - CNTW'(1);
          if (clr_ovf) ovf[k] <= 1'b0;
        end
      end
    end
  end

endmodule
